// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes and filters the raw lines, receives
// 11-bit frames, and decodes make/break/extended scan codes into a held game key.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic [2:0] key,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} scan_state_t;

  // Both lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  logic clk_meta, clk_sync, data_meta, data_sync;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, matching real flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= PS2_clk;
      clk_sync  <= clk_meta;
      data_meta <= PS2_data;
      data_sync <= data_meta;
    end
  end

  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall_edge;

  assign filt_flip = (clk_sync != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall_edge = filt_flip && filt_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Frame receiver: bit_cnt 0 waits for the start bit, 1..8 data, 9 parity, 10 stop.
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic [7:0]    rx_byte;
  logic          rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall_edge) begin
        to_cnt <= '0;
        case (bit_cnt)
          4'd0: if (!data_sync) bit_cnt <= 4'd1;
          4'd9: begin
            par_bit <= data_sync;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            if (data_sync && (^{par_bit, shreg})) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  function automatic logic [2:0] map_code(input logic ext, input logic [7:0] b);
    if (ext) begin
      case (b)
        8'h75:   return 3'd3;
        8'h6B:   return 3'd5;
        8'h74:   return 3'd6;
        8'h72:   return 3'd7;
        default: return 3'd0;
      endcase
    end else begin
      case (b)
        8'h76:   return 3'd1;
        8'h29:   return 3'd2;
        8'h22:   return 3'd3;
        8'h1A:   return 3'd4;
        default: return 3'd0;
      endcase
    end
  endfunction

  scan_state_t state, state_nxt;
  logic [2:0]  key_nxt;
  logic        key_valid_nxt;
  logic [2:0]  code;
  logic        is_break;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      key       <= key_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    key_nxt       = key;
    key_valid_nxt = 1'b0;
    code          = map_code((state == EXT) || (state == EXT_BRK), rx_byte);
    is_break      = (state == BRK) || (state == EXT_BRK);
    if (rx_valid) begin
      if (rx_byte == PREFIX_EXT) begin
        if (state == IDLE) state_nxt = EXT;
      end else if (rx_byte == PREFIX_BRK) begin
        if (state == IDLE)     state_nxt = BRK;
        else if (state == EXT) state_nxt = EXT_BRK;
      end else begin
        state_nxt = IDLE;
        if (code != 3'd0) begin
          if (is_break) begin
            // Releasing a key that was already superseded must not clear the newer one.
            if (code == key) key_nxt = 3'd0;
          end else if (code != key) begin
            key_nxt       = code;
            key_valid_nxt = 1'b1;
          end
        end
      end
    end
  end

endmodule
